// File: rtl/tx_port_pkg.sv
// -----------------------------------------------------------------------------
// tx_port_pkg
//
// Purpose : Shared definitions for the TX port monitor. This covers the parser
//           state encoding, the position of the marker flag in a gate FIFO
//           word, the header field slices, and a saturating counter add.
//
// Header FIFO word layout (65 bits): {flag=1, len[31:0], off[30:0], last}
//   flag : bit 64
//   len  : bits 63:32
//   off  : bits 31:1
//   last : bit 0
// -----------------------------------------------------------------------------
package tx_port_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR_DUP = 2'd1,
        DATA    = 2'd2,
        END_DUP = 2'd3
    } state_e;

    localparam int FLAG_BIT = 64;

    localparam int LEN_MSB  = 63;
    localparam int LEN_LSB  = 32;
    localparam int OFF_MSB  = 31;
    localparam int OFF_LSB  = 1;
    localparam int LAST_BIT = 0;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Word counter add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, inc};
        return s[32] ? COUNT_MAX : s[31:0];
    endfunction

endpackage

// File: rtl/tx_port_monitor_64.sv
// -----------------------------------------------------------------------------
// tx_port_monitor_64
//
// Purpose : Parses the 65-bit event/data stream that a TX channel gate writes
//           into its async FIFO. Each transaction is made of the following
//           parts, in order:
//             - a duplicated header;
//             - payload words;
//             - a duplicated end marker.
//           The header parameters are presented on TXN/TXN_ACK. Payload words
//           are forwarded to the TX buffer with a count of valid 32-bit words.
//           The number of forwarded 32-bit words is reported on DONE.
//
// Optional feature:
//   TX_PORT_MONITOR_TRUNCATE_EN
//     Defined     : words arriving after TXN_LEN is reached are popped and dropped.
//     Not defined : excess words are forwarded as full (2-word) writes, and the
//                   count saturates at 32'hFFFF_FFFF.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RD_DATA/EMPTY   first-word-fall-through gate FIFO read side
//   RD_EN           gate FIFO pop (combinational)
//   TXN/TXN_ACK     transaction request / accept
//   TXN_LEN/OFF/LAST captured header fields
//   WR_DATA/EN/WORDS payload word to TX buffer (registered)
//   WR_FULL         TX buffer back-pressure
//   DONE/DONE_LEN   transaction closed, 32-bit words forwarded
// -----------------------------------------------------------------------------
module tx_port_monitor_64
    import tx_port_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
    input  logic                         RD_EMPTY,
    output logic                         RD_EN,
    output logic                         TXN,
    input  logic                         TXN_ACK,
    output logic [31:0]                  TXN_LEN,
    output logic [30:0]                  TXN_OFF,
    output logic                         TXN_LAST,
    output logic [C_DATA_WIDTH-1:0]      WR_DATA,
    output logic                         WR_EN,
    output logic [1:0]                   WR_WORDS,
    input  logic                         WR_FULL,
    output logic                         DONE,
    output logic [31:0]                  DONE_LEN
);

    state_e                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic                    txn_q, txn_d;
    logic [31:0]             len_q, len_d;
    logic [30:0]             off_q, off_d;
    logic                    last_q, last_d;
    logic [31:0]             count_q, count_d;
    logic                    wr_en_q, wr_en_d;
    logic [C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]              wr_words_q, wr_words_d;
    logic                    done_q, done_d;
    logic [31:0]             done_len_q, done_len_d;

    logic                    rd_en;
    logic                    is_flag;
    logic                    pop_payload;
    logic [31:0]             rem;

    // Flag words are interpreted purely by the state they arrive in; an
    // all-zero header is bit-identical to an end marker.
    assign is_flag = RD_DATA[FLAG_BIT];
    assign rem     = len_q - count_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_en && is_flag) state_d = HDR_DUP;
            HDR_DUP: if (rd_en)            state_d = DATA;
            DATA:    if (rd_en && is_flag) state_d = END_DUP;
            END_DUP: if (rd_en && is_flag) state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Pop control. The duplicate header is dropped without waiting for the
    // ack. A payload word that shows up in its place must obey the same
    // ack/back-pressure rules as in DATA.
    always_comb begin
        rd_en = 1'b0;
        case (state_q)
            IDLE:    rd_en = !RD_EMPTY;
            HDR_DUP: rd_en = !RD_EMPTY && (is_flag || (ack_q && !WR_FULL));
            DATA:    rd_en = !RD_EMPTY && ack_q && !WR_FULL;
            END_DUP: rd_en = !RD_EMPTY;
            default: rd_en = 1'b0;
        endcase
        if (RST) begin
            rd_en = 1'b0;
        end
    end

    assign RD_EN       = rd_en;
    assign pop_payload = rd_en && !is_flag && ((state_q == HDR_DUP) || (state_q == DATA));

    // Datapath and handshake next-state
    always_comb begin
        ack_d      = ack_q;
        txn_d      = txn_q;
        len_d      = len_q;
        off_d      = off_q;
        last_d     = last_q;
        count_d    = count_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        wr_words_d = wr_words_q;
        done_d     = 1'b0;
        done_len_d = done_len_q;

        // The ack is latched so that RD_EN no longer depends on TXN_ACK,
        // which may be held high ahead of the request.
        if (txn_q && TXN_ACK) begin
            ack_d = 1'b1;
            txn_d = 1'b0;
        end

        if ((state_q == IDLE) && rd_en && is_flag) begin
            len_d   = RD_DATA[LEN_MSB:LEN_LSB];
            off_d   = RD_DATA[OFF_MSB:OFF_LSB];
            last_d  = RD_DATA[LAST_BIT];
            txn_d   = 1'b1;
            ack_d   = 1'b0;
            count_d = 32'd0;
        end

        if (pop_payload) begin
            if (rem == 32'd0) begin
`ifdef TX_PORT_MONITOR_TRUNCATE_EN
                // Length reached: word is consumed but not forwarded.
                wr_en_d = 1'b0;
`else
                wr_en_d    = 1'b1;
                wr_data_d  = RD_DATA[C_DATA_WIDTH-1:0];
                wr_words_d = 2'd2;
                count_d    = sat_add(count_q, 2'd2);
`endif
            end else if (rem == 32'd1) begin
                wr_en_d    = 1'b1;
                wr_data_d  = RD_DATA[C_DATA_WIDTH-1:0];
                wr_words_d = 2'd1;
                count_d    = sat_add(count_q, 2'd1);
            end else begin
                // Also taken once count has overrun len: rem wraps to a large value.
                wr_en_d    = 1'b1;
                wr_data_d  = RD_DATA[C_DATA_WIDTH-1:0];
                wr_words_d = 2'd2;
                count_d    = sat_add(count_q, 2'd2);
            end
        end

        if ((state_q == DATA) && rd_en && is_flag) begin
            done_d     = 1'b1;
            done_len_d = count_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_q      <= 1'b0;
            txn_q      <= 1'b0;
            len_q      <= 32'd0;
            off_q      <= 31'd0;
            last_q     <= 1'b0;
            count_q    <= 32'd0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_words_q <= 2'd0;
            done_q     <= 1'b0;
            done_len_q <= 32'd0;
        end else begin
            ack_q      <= ack_d;
            txn_q      <= txn_d;
            len_q      <= len_d;
            off_q      <= off_d;
            last_q     <= last_d;
            count_q    <= count_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_words_q <= wr_words_d;
            done_q     <= done_d;
            done_len_q <= done_len_d;
        end
    end

    assign TXN      = txn_q;
    assign TXN_LEN  = len_q;
    assign TXN_OFF  = off_q;
    assign TXN_LAST = last_q;
    assign WR_EN    = wr_en_q;
    assign WR_DATA  = wr_data_q;
    assign WR_WORDS = wr_words_q;
    assign DONE     = done_q;
    assign DONE_LEN = done_len_q;

endmodule
